sink: RTL and testbench

Traffic sink and checker for the NoC test harness. It sits at a router output port as the receiving end of the traffic-generator flow. It accepts every valid beat and decodes the packed data word into source node, destination, source ID and sequence number. It checks destination and per-source sequence order, keeps receive and error counters, and drives a programmable ready/backpressure pattern back towards the network.

---
 rtl/sink.sv | 104 ++++++++++
 tb/tb_sink.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sink.sv
// sink: NoC traffic sink that decodes, checks and counts beats and drives a ready/backpressure pattern.
module sink #(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 0,
    parameter int NUM_SRC      = 4,
    parameter int READY_PERIOD = 0,
    parameter int READY_STALL  = 1,
    parameter int DONE_COUNT   = 1000,
    parameter int CW           = WIDTH - 2*N_ADDR_WIDTH - 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [31:0]      rx_count,
    output logic [15:0]      err_count,
    output logic             seq_err_seen,
    output logic             dest_err_seen,
    output logic             err_pulse,
    output logic             done
);
    localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam logic [31:0] RUN_LAST   = 32'(READY_PERIOD - READY_STALL - 1);
    localparam logic [31:0] STALL_LAST = 32'(READY_STALL - 1);

    typedef enum logic [1:0] {RESET, RUN, STALL} state_t;

    logic [N_ADDR_WIDTH-1:0] src_node, dest;
    logic [7:0]              id;
    logic [CW-1:0]           seq;
    logic [CW-1:0]           exp_tbl [NUM_SRC];
    logic [IW-1:0]           idx;
    logic                    id_ok, dest_bad, seq_bad, bad;
    logic                    unused_src;
    state_t                  state, state_n;
    logic [31:0]             cnt, cnt_n;

    assign {src_node, dest, id, seq} = data_in;
    assign unused_src = ^src_node;
    assign idx      = id[IW-1:0];
    assign id_ok    = {1'b0, id} < 9'(NUM_SRC);
    assign dest_bad = !id_ok || dest != N_ADDR_WIDTH'(NODE);
    assign seq_bad  = id_ok && seq != exp_tbl[idx];
    assign bad      = dest_bad || seq_bad;
    assign done     = rx_count >= 32'(DONE_COUNT);

    // A good beat has seq == exp, so seq+1 serves both the advance and the resync.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_count      <= '0;
            err_count     <= '0;
            seq_err_seen  <= 1'b0;
            dest_err_seen <= 1'b0;
            err_pulse     <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) exp_tbl[i] <= CW'(1);
        end else begin
            err_pulse <= valid_in && bad;
            if (valid_in) begin
                rx_count      <= rx_count + 32'd1;
                err_count     <= (bad && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
                seq_err_seen  <= seq_err_seen | seq_bad;
                dest_err_seen <= dest_err_seen | dest_bad;
                if (id_ok) exp_tbl[idx] <= seq + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RESET;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ready_out = 1'b0;
        case (state)
            RESET: begin
                state_n = RUN;
                cnt_n   = '0;
            end
            RUN: begin
                ready_out = 1'b1;
                if (READY_PERIOD != 0) begin
                    state_n = cnt == RUN_LAST ? STALL : RUN;
                    cnt_n   = cnt == RUN_LAST ? '0 : cnt + 32'd1;
                end
            end
            STALL: begin
                state_n = cnt == STALL_LAST ? RUN : STALL;
                cnt_n   = cnt == STALL_LAST ? '0 : cnt + 32'd1;
            end
            default: state_n = RESET;
        endcase
    end
endmodule

// File: tb/tb_sink.sv
// tb_sink: randomized and directed checks of sink against a behavioural reference model.
module tb_sink;
    localparam int WIDTH = 20, N = 16, A = 4, NODE = 3, NUM_SRC = 4;
    localparam int RP = 4, RS = 1, DONE_COUNT = 1000, CW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out, seq_err_seen, dest_err_seen, err_pulse, done;
    logic [31:0]      rx_count;
    logic [15:0]      err_count;

    int total = 0, bad = 0;
    int m_rx, m_err, m_since, m_exp [NUM_SRC];
    bit m_seq_seen, m_dest_seen, m_pulse;

    sink #(.WIDTH(WIDTH), .N(N), .N_ADDR_WIDTH(A), .NODE(NODE), .NUM_SRC(NUM_SRC),
           .READY_PERIOD(RP), .READY_STALL(RS), .DONE_COUNT(DONE_COUNT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .rx_count(rx_count), .err_count(err_count), .seq_err_seen(seq_err_seen),
        .dest_err_seen(dest_err_seen), .err_pulse(err_pulse), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_step();
        int id, dest, seq;
        bit sbad, dbad;
        if (!rst) begin
            m_rx = 0; m_err = 0; m_since = 0;
            m_seq_seen = 0; m_dest_seen = 0; m_pulse = 0;
            for (int i = 0; i < NUM_SRC; i++) m_exp[i] = 1;
            return;
        end
        m_since++;
        m_pulse = 0;
        if (!valid_in) return;
        dest = int'(data_in[WIDTH-A-1 -: A]);
        id   = int'(data_in[CW+7 -: 8]);
        seq  = int'(data_in[CW-1:0]);
        dbad = id >= NUM_SRC || dest != NODE;
        sbad = 0;
        if (id < NUM_SRC) begin
            if (seq != m_exp[id]) begin
                sbad = 1;
                m_exp[id] = (seq + 1) % (1 << CW);
            end else
                m_exp[id] = (m_exp[id] + 1) % (1 << CW);
        end
        m_rx++;
        if (sbad || dbad) begin
            m_err = m_err < 65535 ? m_err + 1 : m_err;
            m_pulse = 1;
        end
        m_seq_seen  = m_seq_seen | sbad;
        m_dest_seen = m_dest_seen | dbad;
    endtask

    task automatic check_all();
        bit m_ready;
        m_ready = m_since > 0 && ((m_since - 1) % RP) < RP - RS;
        check("ready_out", 32'(ready_out), 32'(m_ready));
        check("rx_count", rx_count, 32'(m_rx));
        check("err_count", 32'(err_count), 32'(m_err));
        check("seq_err_seen", 32'(seq_err_seen), 32'(m_seq_seen));
        check("dest_err_seen", 32'(dest_err_seen), 32'(m_dest_seen));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("done", 32'(done), 32'(m_rx >= DONE_COUNT));
    endtask

    task automatic cyc(input logic r, input logic v, input int id, input int dest, input int seq);
        @(negedge clk);
        rst      = r;
        valid_in = v;
        data_in  = {A'($urandom_range(0, N - 1)), A'(dest), 8'(id), CW'(seq)};
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, 0, NODE, 7);
        cyc(1'b0, 1'b0, 0, NODE, 0);
    endtask

    initial begin
        int id, dest, seq;
        rst = 1'b0; valid_in = 1'b0; data_in = '0;
        do_reset();
        for (int s = 1; s <= 5; s++) cyc(1'b1, 1'b1, 2, NODE, s);
        foreach (m_exp[i]) check("exp_after_inorder", 32'(m_exp[2]), 32'd6);
        cyc(1'b1, 1'b1, 0, NODE, 1);
        cyc(1'b1, 1'b1, 0, NODE, 2);
        cyc(1'b1, 1'b1, 0, NODE, 4);
        cyc(1'b1, 1'b1, 0, NODE, 5);
        cyc(1'b1, 1'b0, 0, NODE, 0);
        do_reset();
        cyc(1'b1, 1'b1, 1, NODE + 1, 1);
        cyc(1'b1, 1'b1, NUM_SRC, NODE, 1);
        cyc(1'b1, 1'b0, 0, NODE, 0);
        for (int s = 1; s <= 17; s++) cyc(1'b1, 1'b1, 3, NODE, s % 16);
        for (int k = 0; k < 1500; k++) begin
            id   = $urandom_range(0, 5);
            seq  = (id < NUM_SRC && $urandom_range(0, 9) != 0) ? m_exp[id] : $urandom_range(0, 15);
            dest = $urandom_range(0, 9) == 0 ? $urandom_range(0, N - 1) : NODE;
            cyc(1'b1, 1'($urandom_range(0, 3) != 0), id, dest, seq);
        end
        for (int s = 0; s < 40; s++) cyc(1'b1, 1'b1, s % NUM_SRC, NODE, m_exp[s % NUM_SRC]);
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) cyc(1'b1, 1'b1, i, NODE, 1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 0, NODE, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
